// File: rtl/snn_aer_pkg.sv
// Shared types for the spike-to-AER encoder: event layout, FSM encoding and
// the saturating drop-counter helper.
package snn_aer_pkg;

    localparam int AER_ADDR_W = 4;
    localparam int AER_TS_W   = 16;
    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic [AER_TS_W-1:0]   ts;
        logic [AER_ADDR_W-1:0] addr;
    } aer_event_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/spike_aer_encoder_fifo.sv
// Event FIFO: first-word-fall-through view of the head entry; when empty the
// output keeps showing the most recently popped event (zero after reset).
module aer_fifo
    import snn_aer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = $bits(aer_event_t)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [DATA_W-1:0] last_reg;
    logic              push_ok;
    logic              pop_ok;

    // Full comes from the registered count, so a same-cycle pop never frees a slot.
    assign full     = (level_reg == LVL_W'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = empty ? last_reg : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            last_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                last_reg   <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises each accepted spike vector into ascending-address AER events
// stamped with the timestep at which the vector was strobed.
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter  int N_NEURONS  = 16,
    parameter  int TS_W       = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDR_W     = $clog2(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          spike_strobe,
    input  logic [N_NEURONS-1:0]          spike_in,
    output logic                          in_ready,
    output logic                          aer_valid,
    input  logic                          aer_ready,
    output logic [ADDR_W-1:0]             aer_addr,
    output logic [TS_W-1:0]               aer_ts,
    output logic [TS_W-1:0]               ts_now,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int EV_W = TS_W + ADDR_W;
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SCAN = SCAN;

    logic [0:0]            state_reg,    state_next;
    logic [N_NEURONS-1:0]  pending_reg,  pending_next;
    logic [TS_W-1:0]       batch_ts_reg, batch_ts_next;
    logic [TS_W-1:0]       ts_reg,       ts_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EV_W-1:0]   push_data;
    logic [EV_W-1:0]   head_data;

    function automatic logic [ADDR_W-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    assign push_data = {batch_ts_reg, lowest_set(pending_reg)};

    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        batch_ts_next = batch_ts_reg;
        drop_cnt_next = drop_cnt_reg;
        fifo_push     = 1'b0;
        ts_next       = tick ? ts_reg + TS_W'(1) : ts_reg;

        case (state_reg)
            ST_IDLE: begin
                // Batch timestamp is the pre-tick value even if tick fires this cycle.
                if (spike_strobe && (spike_in != '0)) begin
                    pending_next  = spike_in;
                    batch_ts_next = ts_reg;
                    state_next    = ST_SCAN;
                end
            end
            default: begin
                if (spike_strobe) begin
                    drop_cnt_next = sat_inc(drop_cnt_reg);
                end
                if (!fifo_full) begin
                    fifo_push    = 1'b1;
                    // x & (x-1) clears exactly the lowest set bit, matching lowest_set().
                    pending_next = pending_reg & (pending_reg - N_NEURONS'(1));
                    if (pending_next == '0) begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            batch_ts_reg <= '0;
            ts_reg       <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            batch_ts_reg <= batch_ts_next;
            ts_reg       <= ts_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    aer_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (aer_ready),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready  = (state_reg == ST_IDLE);
    assign aer_valid = !fifo_empty;
    assign aer_addr  = head_data[ADDR_W-1:0];
    assign aer_ts    = head_data[EV_W-1:ADDR_W];
    assign ts_now    = ts_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: reset, latency, ordering, stall,
// drop saturation, timestamp wrap and mid-scan reset.
module tb_spike_aer_encoder;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        spike_strobe;
    logic [15:0] spike_in;
    logic        in_ready;
    logic        aer_valid;
    logic        aer_ready;
    logic [3:0]  aer_addr;
    logic [15:0] aer_ts;
    logic [15:0] ts_now;
    logic [7:0]  drop_cnt;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    spike_aer_encoder #(
        .N_NEURONS  (16),
        .TS_W       (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .spike_strobe (spike_strobe),
        .spike_in     (spike_in),
        .in_ready     (in_ready),
        .aer_valid    (aer_valid),
        .aer_ready    (aer_ready),
        .aer_addr     (aer_addr),
        .aer_ts       (aer_ts),
        .ts_now       (ts_now),
        .drop_cnt     (drop_cnt),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // With aer_ready high, every valid cycle pops; expect addresses 0..n-1 at timestamp ts.
    task automatic drain_expect(input string tag, input int n, input logic [15:0] ts);
        int got;
        int budget;
        got = 0;
        budget = 0;
        aer_ready = 1'b1;
        while (got < n && budget < 200) begin
            if (aer_valid) begin
                check({tag, "_addr"}, 32'(aer_addr), 32'(got));
                check({tag, "_ts"}, 32'(aer_ts), 32'(ts));
                got++;
            end
            step();
            budget++;
        end
        check({tag, "_count"}, 32'(got), 32'(n));
        $display("drain %s: %0d events", tag, got);
    endtask

    initial begin
        int exp_addr [4];
        exp_addr = '{0, 5, 10, 15};

        rst_n = 1'b0;
        tick = 1'b0;
        spike_strobe = 1'b0;
        spike_in = '0;
        aer_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(aer_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ts_now", 32'(ts_now), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_addr", 32'(aer_addr), 32'd0);
        check("rst_ts", 32'(aer_ts), 32'd0);
        rst_n = 1'b1;
        step();

        // Empty vector is ignored.
        spike_strobe = 1'b1;
        spike_in = 16'h0000;
        step();
        spike_strobe = 1'b0;
        check("zero_in_ready", 32'(in_ready), 32'd1);
        check("zero_valid", 32'(aer_valid), 32'd0);
        step();
        check("zero_valid2", 32'(aer_valid), 32'd0);
        check("zero_level", 32'(fifo_level), 32'd0);
        $display("txn zero-vector strobe");

        tick = 1'b1;
        repeat (5) step();
        tick = 1'b0;
        check("ts_five", 32'(ts_now), 32'd5);

        // 16'h8421 with aer_ready high: latency and one event per cycle.
        aer_ready = 1'b1;
        spike_strobe = 1'b1;
        spike_in = 16'h8421;
        step();
        spike_strobe = 1'b0;
        check("lat_k1_valid", 32'(aer_valid), 32'd0);
        check("lat_k1_in_ready", 32'(in_ready), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("seq_valid", 32'(aer_valid), 32'd1);
            check("seq_addr", 32'(aer_addr), 32'(exp_addr[i]));
            check("seq_ts", 32'(aer_ts), 32'd5);
            check("seq_in_ready", 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
            $display("txn event addr=%0d ts=%0d", aer_addr, aer_ts);
            step();
        end
        check("seq_empty_valid", 32'(aer_valid), 32'd0);
        check("seq_empty_level", 32'(fifo_level), 32'd0);
        check("seq_hold_addr", 32'(aer_addr), 32'd15);
        check("seq_hold_ts", 32'(aer_ts), 32'd5);

        // Back-pressure: FIFO fills with addresses 0..7, FSM stalls.
        aer_ready = 1'b0;
        spike_strobe = 1'b1;
        spike_in = 16'hFFFF;
        step();
        spike_strobe = 1'b0;
        repeat (8) step();
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(aer_addr), 32'd0);
        step();
        step();
        check("stall_level", 32'(fifo_level), 32'd8);
        check("stall_head", 32'(aer_addr), 32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);

        // Drops while scanning.
        spike_strobe = 1'b1;
        spike_in = 16'h0001;
        repeat (3) step();
        spike_strobe = 1'b0;
        check("drop_three", 32'(drop_cnt), 32'd3);
        check("drop_head", 32'(aer_addr), 32'd0);
        $display("txn three drops, drop_cnt=%0d", drop_cnt);
        drain_expect("ffff", 16, 16'd5);
        check("ffff_in_ready", 32'(in_ready), 32'd1);
        check("ffff_level", 32'(fifo_level), 32'd0);

        // Saturation: stall a new scan and strobe 300 more times.
        aer_ready = 1'b0;
        spike_strobe = 1'b1;
        spike_in = 16'hFFFF;
        step();
        spike_in = 16'h0001;
        repeat (100) step();
        check("drop_103", 32'(drop_cnt), 32'd103);
        repeat (152) step();
        check("drop_sat", 32'(drop_cnt), 32'd255);
        repeat (48) step();
        spike_strobe = 1'b0;
        check("drop_hold", 32'(drop_cnt), 32'd255);
        $display("txn 300 drops, drop_cnt=%0d", drop_cnt);
        drain_expect("sat", 16, 16'd5);

        // Timestamp wrap with tick and strobe in the same cycle.
        tick = 1'b1;
        repeat (65530) step();
        tick = 1'b0;
        check("ts_max", 32'(ts_now), 32'd65535);
        aer_ready = 1'b1;
        tick = 1'b1;
        spike_strobe = 1'b1;
        spike_in = 16'h0003;
        step();
        tick = 1'b0;
        spike_strobe = 1'b0;
        check("ts_wrap", 32'(ts_now), 32'd0);
        step();
        check("wrap_e0_valid", 32'(aer_valid), 32'd1);
        check("wrap_e0_addr", 32'(aer_addr), 32'd0);
        check("wrap_e0_ts", 32'(aer_ts), 32'd65535);
        step();
        check("wrap_e1_addr", 32'(aer_addr), 32'd1);
        check("wrap_e1_ts", 32'(aer_ts), 32'd65535);
        step();
        check("wrap_done", 32'(aer_valid), 32'd0);
        $display("txn wrap events stamped %0d", aer_ts);

        // Reset mid-scan with four events queued.
        aer_ready = 1'b0;
        spike_strobe = 1'b1;
        spike_in = 16'hFFFF;
        step();
        spike_strobe = 1'b0;
        repeat (4) step();
        check("mid_level", 32'(fifo_level), 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(aer_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        step();
        rst_n = 1'b1;
        aer_ready = 1'b1;
        step();
        check("post_ts", 32'(ts_now), 32'd0);
        check("post_drop", 32'(drop_cnt), 32'd0);
        check("post_addr", 32'(aer_addr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("post_no_event", 32'(aer_valid), 32'd0);
            step();
        end
        check("post_in_ready", 32'(in_ready), 32'd1);
        $display("txn mid-scan reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Collects the per-timestep spike vector from a row of neurons and serialises every asserted spike into an address-event (AER) stream.
- Each event carries the neuron index and timestep, and leaves through a valid/ready interface toward the crossbar router or a host monitor.
- This is the consumer end of the neuron spike output: neurons emit parallel spikes, and this block emits ordered, timestamped events.
- Synthesizable and fixed-width; no real types.

Parameters:
- N_NEURONS, 16, number of spike inputs (2..256)
- TS_W, 16, timestep counter width
- FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
- ADDR_W, $clog2(N_NEURONS), neuron address width (derived, not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle pulse; advances timestep counter
- spike_strobe  in  1  spike_in valid this cycle
- spike_in  in  N_NEURONS  spike vector, bit i = neuron i fired
- in_ready  out  1  encoder can accept a new vector (pending set empty)
- aer_valid  out  1  event available
- aer_ready  in  1  downstream accepts event
- aer_addr  out  ADDR_W  neuron index of head event
- aer_ts  out  TS_W  timestep of head event
- ts_now  out  TS_W  current timestep counter
- drop_cnt  out  8  vectors dropped, saturating at 255
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate): FSM=IDLE; pending=0; ts counter=0; FIFO emptied.
  - Outputs at reset: aer_valid=0, aer_addr=0, aer_ts=0, in_ready=1, ts_now=0, drop_cnt=0, fifo_level=0.
  - Reset mid-scan discards pending spikes and queued events; no partial event survives.
- Timestep counter: increments on tick; wraps from 2^TS_W-1 to 0.
- in_ready = (state==IDLE).
- FSM states IDLE and SCAN:
  - IDLE, spike_strobe=1, spike_in!=0: pending<=spike_in; batch_ts<=ts counter value before any same-cycle tick increment; go to SCAN.
  - IDLE, spike_strobe=1, spike_in==0: no action, stay IDLE.
  - SCAN, spike_strobe=1: whole vector dropped; drop_cnt+1, saturating. pending is unchanged.
  - SCAN, each cycle: if FIFO not full, push {lowest set pending index, batch_ts} and clear that bit. If that was the last set bit, go to IDLE next cycle.
  - SCAN, FIFO full: stall; pending and state hold.
- Full is evaluated on the registered count. A pop in the same cycle does not unblock a push while full.
- Ordering: within a vector, events are in ascending address order. Vectors are emitted in strobe order.
- Latency: strobe in cycle k gives SCAN in k+1 and first push at the end of k+1, so aer_valid=1 in cycle k+2. Then one event per cycle while the FIFO has room.
- A vector with P spikes returns in_ready to 1 in cycle k+1+P when there are no stalls.
- FIFO handshake:
  - aer_valid = (level!=0).
  - aer_addr and aer_ts show the head entry and are stable while aer_valid && !aer_ready.
  - Pop on aer_valid && aer_ready.
  - Simultaneous push and pop when not full: level unchanged.
  - Pop when empty is ignored.
  - When the FIFO is empty, aer_addr and aer_ts hold their last value (0 after reset).
- drop_cnt holds at 255 once reached. It is cleared only by reset.

Decomposition:
- Package snn_aer_pkg holds:
  - typedef aer_event_t (packed struct: ts, addr) built from package-level ADDR_W/TS_W defaults
  - localparam DROP_CNT_W=8
  - FSM enum enc_state_t {IDLE, SCAN}
- One sub-module: aer_fifo, a synchronous FIFO of aer_event_t with push, pop, full, empty and level.
- The priority encoder (lowest set bit) is an inline function in the encoder, not a separate module.

Test Plan:
- Reset, then strobe spike_in=16'h0000 -> in_ready stays 1, aer_valid stays 0, fifo_level=0.
- ts_now=5; strobe spike_in=16'h8421, aer_ready=1 -> aer_valid first high 2 cycles after strobe; events (0,5),(5,5),(10,5),(15,5) on consecutive cycles; in_ready back high 5 cycles after strobe.
- aer_ready=0, strobe 16'hFFFF with FIFO_DEPTH=8 -> 8 events queued (addr 0..7), fifo_level=8, FSM stalls in SCAN, head held at addr 0. Release aer_ready -> addresses 8..15 follow in order with no loss.
- In SCAN, strobe 16'h0001 three times -> drop_cnt=3, queued sequence unaltered. Force 300 drops -> drop_cnt=255.
- tick and strobe in the same cycle with ts_now=2^TS_W-1 -> events stamped 65535; ts_now reads 0 next cycle.
- Assert rst_n=0 mid-scan with fifo_level=4 -> aer_valid=0 and in_ready=1 immediately. After release, no stale events appear and ts_now=0.
